// File: rtl/galaga_frame_ctrl_if.sv
// Bundles the VGA-side inputs and the sprite-state outputs of the Galaga frame sequencer.
// master drives vsync/buttons and reads sprite state; slave is the sequencer itself.
interface galaga_frame_ctrl_if;
    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic [9:0] rocket_x;
    logic [9:0] missile_x;
    logic [9:0] missile_y;
    logic       missile_active;
    logic       frame_tick;
    logic [7:0] frame_cnt;
    logic       busy;

    modport master (
        output vsync, btn_left, btn_right, btn_fire,
        input  rocket_x, missile_x, missile_y, missile_active,
        input  frame_tick, frame_cnt, busy
    );

    modport slave (
        input  vsync, btn_left, btn_right, btn_fire,
        output rocket_x, missile_x, missile_y, missile_active,
        output frame_tick, frame_cnt, busy
    );
endinterface

// File: rtl/galaga_frame_ctrl.sv
// Per-frame sequencer: on each vsync fall it moves the rocket, then launches/advances the missile.
// All sprite coordinates are registers updated inside vertical blanking.
module galaga_frame_ctrl #(
    parameter int ROCKET_Y = 460,
    parameter int ROCKET_W = 11,
    parameter int X_RESET  = 315,
    parameter int X_MAX    = 629,
    parameter int STEP     = 4,
    parameter int MSPEED   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    galaga_frame_ctrl_if.slave   frame_if
);

    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] XMAX_W   = 11'(X_MAX);
    localparam logic [9:0]  XRST_W   = 10'(X_RESET);
    localparam logic [9:0]  HALF_W   = 10'(ROCKET_W / 2);
    localparam logic [9:0]  LAUNCH_Y = 10'(ROCKET_Y - 4);
    localparam logic [9:0]  MSPD_W   = 10'(MSPEED);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROCKET  = 2'd1,
        S_MISSILE = 2'd2
    } state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
    } missile_t;

    logic [1:0] vs_sync_q, left_sync_q, right_sync_q, fire_sync_q;
    logic       vs_s, left_s, right_s, fire_s;
    logic       vs_prev_q, fire_prev_q;
    logic       tick_d, fire_rise;

    state_e     state_q, state_d;
    logic       frame_tick_q;
    logic [7:0] frame_cnt_q;
    logic       busy_q;
    logic       fire_pend_q, fire_pend_d;
    logic [9:0] rocket_x_q, rocket_x_d;
    missile_t   missile_q, missile_d;
    logic [10:0] rx_ext, rx_plus;

    // Two-flop synchronizers; vsync idles high so its chain resets to 1 to avoid a false tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_sync_q    <= 2'b11;
            left_sync_q  <= 2'b00;
            right_sync_q <= 2'b00;
            fire_sync_q  <= 2'b00;
            vs_prev_q    <= 1'b1;
            fire_prev_q  <= 1'b0;
        end else begin
            vs_sync_q    <= {vs_sync_q[0],    frame_if.vsync};
            left_sync_q  <= {left_sync_q[0],  frame_if.btn_left};
            right_sync_q <= {right_sync_q[0], frame_if.btn_right};
            fire_sync_q  <= {fire_sync_q[0],  frame_if.btn_fire};
            vs_prev_q    <= vs_s;
            fire_prev_q  <= fire_s;
        end
    end

    assign vs_s      = vs_sync_q[1];
    assign left_s    = left_sync_q[1];
    assign right_s   = right_sync_q[1];
    assign fire_s    = fire_sync_q[1];
    assign tick_d    = vs_prev_q & ~vs_s;
    assign fire_rise = fire_s & ~fire_prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (frame_tick_q) state_d = S_ROCKET;
            S_ROCKET:  state_d = S_MISSILE;
            S_MISSILE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Rocket move is evaluated in 11 bits so both clamps compare without wrap.
    assign rx_ext  = {1'b0, rocket_x_q};
    assign rx_plus = rx_ext + STEP_W;

    always_comb begin
        rocket_x_d = rocket_x_q;
        if (state_q == S_ROCKET) begin
            if (left_s && !right_s)
                rocket_x_d = (rx_ext >= STEP_W) ? 10'(rx_ext - STEP_W) : 10'd0;
            else if (right_s && !left_s)
                rocket_x_d = (rx_plus > XMAX_W) ? XMAX_W[9:0] : rx_plus[9:0];
        end
    end

    always_comb begin
        missile_d = missile_q;
        if (state_q == S_MISSILE) begin
            if (!missile_q.active) begin
                if (fire_pend_q) begin
                    missile_d.active = 1'b1;
                    missile_d.x      = rocket_x_q + HALF_W;
                    missile_d.y      = LAUNCH_Y;
                end
            end else if (missile_q.y >= MSPD_W) begin
                missile_d.y = missile_q.y - MSPD_W;
            end else begin
                missile_d.active = 1'b0;
                missile_d.y      = 10'd0;
            end
        end
    end

    // A fresh press in the clearing cycle must survive, so the set term has priority.
    always_comb begin
        fire_pend_d = fire_pend_q;
        if (state_q == S_MISSILE) fire_pend_d = 1'b0;
        if (fire_rise)            fire_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            busy_q       <= 1'b0;
            fire_pend_q  <= 1'b0;
            rocket_x_q   <= XRST_W;
            missile_q    <= '0;
        end else begin
            state_q      <= state_d;
            frame_tick_q <= tick_d;
            frame_cnt_q  <= frame_cnt_q + {7'd0, tick_d};
            busy_q       <= (state_d != S_IDLE);
            fire_pend_q  <= fire_pend_d;
            rocket_x_q   <= rocket_x_d;
            missile_q    <= missile_d;
        end
    end

    assign frame_if.rocket_x       = rocket_x_q;
    assign frame_if.missile_x      = missile_q.x;
    assign frame_if.missile_y      = missile_q.y;
    assign frame_if.missile_active = missile_q.active;
    assign frame_if.frame_tick     = frame_tick_q;
    assign frame_if.frame_cnt      = frame_cnt_q;
    assign frame_if.busy           = busy_q;

endmodule
